// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 raster timing generator and pixel sink.
// Two free-running counters walk the frame. Every output is decoded
// combinationally from them. Pixel requests (pix_x/pix_y) lead the active
// area by one clock, so the generator's registered pix_data lines up with
// rgb_valid.
module vga_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 40,
    parameter int unsigned H_LEFT   = 8,
    parameter int unsigned H_VALID  = 640,
    parameter int unsigned H_RIGHT  = 8,
    parameter int unsigned H_FRONT  = 8,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 25,
    parameter int unsigned V_TOP    = 8,
    parameter int unsigned V_VALID  = 480,
    parameter int unsigned V_BOTTOM = 8,
    parameter int unsigned V_FRONT  = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_end
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int unsigned HS      = H_SYNC + H_BACK + H_LEFT;
    localparam int unsigned VS      = V_SYNC + V_BACK + V_TOP;

    // 10-bit forms of the decode boundaries
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO  = 10'(HS);
    localparam logic [9:0] H_ACT_HI  = 10'(HS + H_VALID);
    localparam logic [9:0] H_REQ_LO  = 10'(HS - 1);
    localparam logic [9:0] H_REQ_HI  = 10'(HS + H_VALID - 1);
    localparam logic [9:0] V_ACT_LO  = 10'(VS);
    localparam logic [9:0] V_ACT_HI  = 10'(VS + V_VALID);
    localparam logic [9:0] NO_REQ    = 10'h3FF;

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       h_last;
    logic       h_act, h_req, v_act, pix_req;

    // Next-state for the horizontal and vertical scan counters
    always_comb begin
        h_last  = (cnt_h_q == H_LAST);
        cnt_h_d = h_last ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (h_last) begin
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
        end
    end

    // Scan counter registers; reset restarts the scan at (0,0)
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Output decode from the counters and the incoming pixel
    always_comb begin
        h_act     = (cnt_h_q >= H_ACT_LO) && (cnt_h_q < H_ACT_HI);
        h_req     = (cnt_h_q >= H_REQ_LO) && (cnt_h_q < H_REQ_HI);
        v_act     = (cnt_v_q >= V_ACT_LO) && (cnt_v_q < V_ACT_HI);
        pix_req   = h_req && v_act;
        rgb_valid = h_act && v_act;
        hsync     = (cnt_h_q < H_SYNC_W);
        vsync     = (cnt_v_q < V_SYNC_W);
        // Offsets are only taken inside the request window, so no underflow
        pix_x     = pix_req ? (cnt_h_q - H_REQ_LO) : NO_REQ;
        pix_y     = pix_req ? (cnt_v_q - V_ACT_LO) : NO_REQ;
        rgb       = rgb_valid ? pix_data : 16'h0000;
        frame_end = h_last && (cnt_v_q == V_LAST);
    end

endmodule
